// File: rtl/rl_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rl_pipeline_pkg
// Description : Shared constants for the range-limited force pipeline:
//               scheduler FSM state encoding, default BRAM address width
//               and read latency, and the pair-count width.
// Revision    : 1.0 - initial release
// ============================================================================
package rl_pipeline_pkg;

  // Defaults shared with the position BRAM wrappers
  localparam int c_default_addr_width   = 9;
  localparam int c_default_read_latency = 1;
  localparam int c_pair_cnt_width       = 32;

  // Pair scheduler FSM encoding
  localparam int                   c_state_w  = 2;
  localparam logic [c_state_w-1:0] c_st_idle  = 2'd0;
  localparam logic [c_state_w-1:0] c_st_run   = 2'd1;
  localparam logic [c_state_w-1:0] c_st_drain = 2'd2;
  localparam logic [c_state_w-1:0] c_st_done  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rl_valid_delay.sv
`default_nettype none
// ============================================================================
// Module      : rl_valid_delay
// Description : DEPTH-deep valid shift register. dout is din delayed by
//               DEPTH cycles; in_flight is high while any stage holds a 1.
//               Cleared synchronously by rst.
// Revision    : 1.0 - initial release
// ============================================================================
module rl_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic in_flight
);

  logic [DEPTH-1:0] r_pipe;

  generate
    if (DEPTH == 1) begin : g_single
      // Single-stage delay
      always_ff @(posedge clk) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= din;
      end
    end else begin : g_multi
      // Shift din in at bit 0, out at the top
      always_ff @(posedge clk) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= {r_pipe[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout      = r_pipe[DEPTH-1];
  assign in_flight = |r_pipe;

endmodule
`default_nettype wire

// File: rtl/rl_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rl_pair_scheduler
// Description : Sequences one range-limited force tile. Walks every
//               home x neighbor pair, drives the position BRAM read ports,
//               aligns r2_enable to BRAM latency, throttles on stall and on
//               the outstanding-result limit, and pulses done once the last
//               force result has returned.
//               Optional macro RL_SKIP_SELF_PAIR_EN: pairs whose home and
//               neighbor indices match become bubbles (not issued/counted).
// Revision    : 1.0 - initial release
// ============================================================================
module rl_pair_scheduler
  import rl_pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH      = c_default_addr_width,
  parameter int READ_LATENCY    = c_default_read_latency,
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_WIDTH       = c_pair_cnt_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] home_last,
  input  logic [ADDR_WIDTH-1:0] nbr_last,
  input  logic                  stall,
  input  logic                  force_valid,
  output logic                  rden,
  output logic [ADDR_WIDTH-1:0] home_rdaddr,
  output logic [ADDR_WIDTH-1:0] nbr_rdaddr,
  output logic                  r2_enable,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pair_count
);

  // Outstanding counter must hold MAX_OUTSTANDING itself
  localparam int                 c_out_w   = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [c_out_w-1:0] c_max_out = c_out_w'(MAX_OUTSTANDING);

  logic [c_state_w-1:0]  r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_home_last, r_nbr_last;
  logic [ADDR_WIDTH-1:0] r_home_ptr, r_nbr_ptr;
  logic [ADDR_WIDTH-1:0] r_home_addr, r_nbr_addr;
  logic [c_out_w-1:0]    r_outstanding, w_out_next;
  logic [CNT_WIDTH-1:0]  r_pair_count;
  logic                  r_rden;
  logic                  w_start_acc, w_advance, w_issue, w_final, w_self;
  logic                  w_at_end, w_r2, w_in_flight;

  // A self pair only matters when skipping is compiled in
`ifdef RL_SKIP_SELF_PAIR_EN
  assign w_self = (r_home_ptr == r_nbr_ptr);
`else
  assign w_self = 1'b0;
`endif

  assign w_at_end = (r_home_ptr == r_home_last) && (r_nbr_ptr == r_nbr_last);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_next_state;
  end

  // Next-state logic; DRAIN exit looks at the post-edge outstanding count so
  // done follows the final force_valid by one cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (start) w_next_state = c_st_run;
      c_st_run:   if (w_final) w_next_state = c_st_drain;
      c_st_drain: if ((w_out_next == '0) && !w_in_flight) w_next_state = c_st_done;
      c_st_done:  w_next_state = c_st_idle;
      default:    w_next_state = c_st_idle;
    endcase
  end

  // Per-state control: start acceptance, pair stepping and issue decision
  always_comb begin
    w_start_acc = 1'b0;
    w_advance   = 1'b0;
    w_issue     = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      c_st_idle: w_start_acc = start;
      c_st_run: begin
        w_advance = !stall && (r_outstanding < c_max_out);
        w_issue   = w_advance && !w_self;
        w_final   = w_advance && w_at_end;
      end
      default: ;
    endcase
  end

  // Outstanding count: simultaneous issue and return cancel; never below 0
  always_comb begin
    w_out_next = r_outstanding;
    if (w_issue && !force_valid)
      w_out_next = r_outstanding + c_out_w'(1);
    else if (!w_issue && force_valid && (r_outstanding != '0))
      w_out_next = r_outstanding - c_out_w'(1);
  end

  // Registered read port, pair pointers, counters and latched bounds
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rden        <= 1'b0;
      r_home_addr   <= '0;
      r_nbr_addr    <= '0;
      r_home_ptr    <= '0;
      r_nbr_ptr     <= '0;
      r_home_last   <= '0;
      r_nbr_last    <= '0;
      r_pair_count  <= '0;
      r_outstanding <= '0;
    end else begin
      r_rden        <= w_issue;
      r_outstanding <= w_out_next;
      if (w_start_acc) begin
        r_home_last  <= home_last;
        r_nbr_last   <= nbr_last;
        r_home_ptr   <= '0;
        r_nbr_ptr    <= '0;
        r_home_addr  <= '0;
        r_nbr_addr   <= '0;
        r_pair_count <= '0;
      end
      if (w_issue) begin
        r_home_addr  <= r_home_ptr;
        r_nbr_addr   <= r_nbr_ptr;
        r_pair_count <= r_pair_count + CNT_WIDTH'(1);
      end
      if (w_advance) begin
        if (r_nbr_ptr == r_nbr_last) begin
          r_nbr_ptr  <= '0;
          r_home_ptr <= r_home_ptr + ADDR_WIDTH'(1);
        end else begin
          r_nbr_ptr  <= r_nbr_ptr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  rl_valid_delay #(
    .DEPTH (READ_LATENCY)
  ) u_valid_delay (
    .clk       (clk),
    .rst       (rst),
    .din       (r_rden),
    .dout      (w_r2),
    .in_flight (w_in_flight)
  );

  assign rden        = r_rden;
  assign home_rdaddr = r_home_addr;
  assign nbr_rdaddr  = r_nbr_addr;
  assign r2_enable   = w_r2;
  assign busy        = (r_state == c_st_run) || (r_state == c_st_drain);
  assign done        = (r_state == c_st_done);
  assign pair_count  = r_pair_count;

endmodule
`default_nettype wire
